// File: rtl/seq_divider_p_if.sv
// -----------------------------------------------------------------------------
// seq_divider_p_if
// Handshake and operand/result bundle between the control sequencer (master)
// and the seq_divider_p divide engine (slave).
//
// Signals:
//   start        master->slave  request, accepted only while busy=0
//   signed_mode  master->slave  1 = two's-complement operands (sampled with start)
//   X            master->slave  dividend, WIDTH bits (sampled with start)
//   Y            master->slave  divisor, WIDTH bits (sampled with start)
//   busy         slave->master  high from accept edge until the result edge
//   valid        slave->master  one-cycle pulse, results valid
//   quot         slave->master  quotient, WIDTH bits
//   rem          slave->master  remainder, WIDTH bits
//   div_by_zero  slave->master  Y was zero for the current result
//   overflow     slave->master  signed min / -1 case for the current result
// -----------------------------------------------------------------------------
interface seq_divider_p_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, X, Y,
    input  busy, valid, quot, rem, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_mode, X, Y,
    output busy, valid, quot, rem, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_p.sv
// -----------------------------------------------------------------------------
// seq_divider_p
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Produces quotient and remainder of X/Y in WIDTH+1 cycles after accept
// (1 cycle for a zero divisor). Optional signed mode truncates toward zero:
// the quotient is negated when operand signs differ and the remainder takes
// the sign of the dividend.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//   SIGNED_EN  1 = bus.signed_mode honoured, 0 = always unsigned
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   seq_divider_p_if slave modport (start/operands in, busy/valid/results out)
// -----------------------------------------------------------------------------
module seq_divider_p #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  seq_divider_p_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t           state;

  // Working registers
  logic [WIDTH-1:0] dvd_reg;    // dividend magnitude, shifts out MSB-first and fills with quotient bits
  logic [WIDTH-1:0] dvs_reg;    // divisor magnitude
  logic [WIDTH-1:0] prem_reg;   // partial remainder
  logic [CW-1:0]    cnt_reg;    // iterations still to run
  logic             neg_q_reg;  // negate quotient in SIGN
  logic             neg_r_reg;  // negate remainder in SIGN
  logic             ovf_reg;    // min / -1 detected at accept
  logic             zero_reg;   // divisor was zero at accept

  // Registered outputs
  logic             busy_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             dbz_reg;
  logic             ovf_out_reg;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------------
  logic             signed_act;
  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic             y_zero;
  logic             min_by_neg1;

  generate
    if (SIGNED_EN != 0) begin : g_signed
      assign signed_act = bus.signed_mode;
    end else begin : g_unsigned
      assign signed_act = 1'b0;
    end
  endgenerate

  assign x_neg  = signed_act & bus.X[WIDTH-1];
  assign y_neg  = signed_act & bus.Y[WIDTH-1];

  // Two's-complement negation of the most negative value yields the same bit
  // pattern, which read as unsigned is exactly 2^(WIDTH-1): no width is lost.
  assign x_mag  = x_neg ? (~bus.X + 1'b1) : bus.X;
  assign y_mag  = y_neg ? (~bus.Y + 1'b1) : bus.Y;
  assign y_zero = (bus.Y == '0);

  assign min_by_neg1 = signed_act
                     & (bus.X == {1'b1, {(WIDTH-1){1'b0}}})
                     & (bus.Y == {WIDTH{1'b1}});

  // ---------------------------------------------------------------------------
  // One restoring iteration
  // ---------------------------------------------------------------------------
  // The shifted remainder needs WIDTH+1 bits: the partial remainder is always
  // below the divisor, so after the shift it is below 2*divisor.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] dvd_next;

  assign shifted   = {prem_reg, dvd_reg[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvs_reg};
  assign fits      = (shifted >= {1'b0, dvs_reg});
  assign prem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_next  = {dvd_reg[WIDTH-2:0], fits};

  // Sign fix-up applied to the magnitude results
  logic [WIDTH-1:0] quot_signed;
  logic [WIDTH-1:0] rem_signed;

  assign quot_signed = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
  assign rem_signed  = neg_r_reg ? (~prem_reg + 1'b1) : prem_reg;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      prem_reg    <= '0;
      cnt_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      zero_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      dbz_reg     <= 1'b0;
      ovf_out_reg <= 1'b0;
    end else begin
      // valid is a single-cycle pulse; only SIGN raises it
      valid_reg <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_reg    <= 1'b1;
            dbz_reg     <= 1'b0;
            ovf_out_reg <= 1'b0;
            prem_reg    <= '0;
            zero_reg    <= y_zero;
            ovf_reg     <= min_by_neg1;
            neg_q_reg   <= x_neg ^ y_neg;
            neg_r_reg   <= x_neg;
            dvs_reg     <= y_mag;
            cnt_reg     <= CW'(WIDTH);
            if (y_zero) begin
              // Raw dividend is returned as the remainder; skip iterations.
              dvd_reg <= bus.X;
              state   <= SIGN;
            end else begin
              dvd_reg <= x_mag;
              state   <= CALC;
            end
          end
        end

        CALC: begin
          prem_reg <= prem_next;
          dvd_reg  <= dvd_next;
          cnt_reg  <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            state <= SIGN;
          end
        end

        SIGN: begin
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          if (zero_reg) begin
            quot_reg    <= {WIDTH{1'b1}};
            rem_reg     <= dvd_reg;
            dbz_reg     <= 1'b1;
            ovf_out_reg <= 1'b0;
          end else begin
            quot_reg    <= quot_signed;
            rem_reg     <= rem_signed;
            dbz_reg     <= 1'b0;
            ovf_out_reg <= ovf_reg;
          end
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.valid       = valid_reg;
  assign bus.quot        = quot_reg;
  assign bus.rem         = rem_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.overflow    = ovf_out_reg;

endmodule

// File: tb/tb_seq_divider_p.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_p
// Self-checking bench for seq_divider_p (WIDTH=4, signed mode enabled).
// Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_seq_divider_p;

  localparam int W = 4;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  seq_divider_p_if #(.WIDTH(W)) bus ();

  seq_divider_p #(
    .WIDTH     (W),
    .SIGNED_EN (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer division truncating toward zero in signed mode.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov, output int lat);
    int xs;
    int ys;
    if (y == 0) begin
      q = '1; r = x; dz = 1'b1; ov = 1'b0; lat = 1;
    end else if (sm) begin
      xs  = int'($signed(x));
      ys  = int'($signed(y));
      q   = W'(xs / ys);
      r   = W'(xs % ys);
      dz  = 1'b0;
      ov  = (xs == -(2 ** (W - 1))) && (ys == -1);
      lat = W + 1;
    end else begin
      q = x / y; r = x % y; dz = 1'b0; ov = 1'b0; lat = W + 1;
    end
  endtask

  // Drives start at the current negedge and returns at the negedge where
  // valid is observed, so a caller may chain a new start into that cycle.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sm, input bit spam);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         eov;
    int           elat;
    int           k;
    int           busy_cnt;
    model(x, y, sm, eq, er, edz, eov, elat);
    check("idle_before_start", bus.busy, 0);
    bus.start       = 1'b1;
    bus.X           = x;
    bus.Y           = y;
    bus.signed_mode = sm;
    @(negedge clk);
    bus.start       = 1'b0;
    // operands after accept must not matter
    bus.X           = W'($urandom);
    bus.Y           = W'($urandom);
    bus.signed_mode = 1'($urandom);
    k        = 1;
    busy_cnt = 0;
    while (!bus.valid && k < 40) begin
      if (bus.busy) busy_cnt++;
      if (spam) bus.start = 1'($urandom);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check("latency", k - 1, elat);
    check("busy_cycles", busy_cnt, elat);
    check("busy_at_valid", bus.busy, 0);
    check("quot", bus.quot, eq);
    check("rem", bus.rem, er);
    check("div_by_zero", bus.div_by_zero, edz);
    check("overflow", bus.overflow, eov);
    $display("op x=%0d y=%0d signed=%0d -> quot=%0d rem=%0d dz=%0d ov=%0d lat=%0d",
             x, y, sm, bus.quot, bus.rem, bus.div_by_zero, bus.overflow, k - 1);
  endtask

  // One idle cycle after a result: valid must drop, results must hold.
  task automatic idle_after;
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    q0 = bus.quot;
    r0 = bus.rem;
    bus.start = 1'b0;
    @(negedge clk);
    check("valid_pulse", bus.valid, 0);
    check("quot_hold", bus.quot, q0);
    check("rem_hold", bus.rem, r0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_quot"}, bus.quot, 0);
    check({tag, "_rem"}, bus.rem, 0);
    check({tag, "_dz"}, bus.div_by_zero, 0);
    check({tag, "_ov"}, bus.overflow, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst             = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.X           = '0;
    bus.Y           = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(4'd15, 4'd8, 1'b0, 1'b0);
    run_op(4'd10, 4'd2, 1'b0, 1'b0);      // started in the valid cycle
    idle_after();
    run_op(4'b1001, 4'd2, 1'b1, 1'b0);    // -7 / 2
    idle_after();
    run_op(4'b1001, 4'd2, 1'b0, 1'b0);    // 9 / 2
    idle_after();
    run_op(4'd9, 4'd0, 1'b0, 1'b0);       // divide by zero
    idle_after();
    run_op(4'd7, 4'd3, 1'b0, 1'b0);       // flag clears
    idle_after();
    run_op(4'b1000, 4'b1111, 1'b1, 1'b1); // min / -1, start spammed while busy
    idle_after();
    check("single_valid", bus.valid, 0);

    // Reset in the middle of CALC
    bus.start = 1'b1; bus.X = 4'd13; bus.Y = 4'd3; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    begin
      int saw_valid;
      saw_valid = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus.valid) saw_valid = 1;
      end
      rst = 1'b1;
      @(negedge clk);
      if (bus.valid) saw_valid = 1;
      check("no_valid_after_abort", saw_valid, 0);
    end
    run_op(4'd13, 4'd3, 1'b0, 1'b0);
    idle_after();

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        x = 4'b1000;
        y = 4'b1111;
      end
      run_op(x, y, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_after();
    end
    idle_after();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
